// File: rtl/u_rbs24_seq.sv
// u_rbs24_seq: digit-serial unsigned ripple-borrow subtractor.
//
// Computes a - b over N bits, CHUNK bits per clock, and carries one borrow bit
// from each chunk into the next. The result is {borrow, (a - b) mod 2^N}.
// A valid/ready handshake is used on both the operand side and the result side.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   in_valid        operand pair valid
//   in_ready        block can accept operands (IDLE)
//   a, b            minuend and subtrahend, unsigned, N bits
//   out_valid       result valid (DONE)
//   out_ready       consumer accepts the result
//   u_rbs24_seq_out [N-1:0] difference mod 2^N, [N] borrow (1 iff a < b)
//   busy            high in RUN or DONE
module u_rbs24_seq #(
    parameter int unsigned N     = 24,
    parameter int unsigned CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   u_rbs24_seq_out,
    output logic         busy
);

    localparam int unsigned NumChunks = N / CHUNK;
    localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

    // Refuse to elaborate if the operand does not split into whole chunks.
    if ((N % CHUNK) != 0) begin : g_chunk_check
        $error("u_rbs24_seq: CHUNK must divide N");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [N-1:0]      res_q, res_d;
    logic              borrow_q, borrow_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N:0]        out_q, out_d;

    logic [CHUNK-1:0]  diff;
    logic              chunk_bout;

    // Chained full subtractor over the low CHUNK bits of the operand registers.
    always_comb begin : p_chunk_sub
        logic bin;
        bin  = borrow_q;
        diff = '0;
        for (int i = 0; i < CHUNK; i++) begin
            diff[i] = a_q[i] ^ b_q[i] ^ bin;
            bin     = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bin);
        end
        chunk_bout = bin;
    end

    always_comb begin : p_next
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Difference chunks enter from the top so that after the last
                // chunk the least significant chunk sits at bit 0.
                res_d    = (res_q >> CHUNK) | (N'(diff) << (N - CHUNK));
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                borrow_d = chunk_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    out_d   = {chunk_bout, res_d};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    // The output register only loads on completion, so the last result stays
    // visible through IDLE and the next RUN.
    assign in_ready        = (state_q == StIdle);
    assign out_valid       = (state_q == StDone);
    assign busy            = (state_q != StIdle);
    assign u_rbs24_seq_out = out_q;

endmodule

// File: tb/tb_u_rbs24_seq.sv
// Scoreboard bench for u_rbs24_seq: the driver pushes expected results at
// operand acceptance, the monitor pops and compares at each result handshake.
module tb_u_rbs24_seq;

    localparam int unsigned N     = 24;
    localparam int unsigned CHUNK = 4;
    localparam int          LAT   = N / CHUNK;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    dout;
    logic          busy;

    typedef struct {
        logic [N:0] exp;
        int         acc;
    } item_t;

    item_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rdy_random = 0;

    u_rbs24_seq #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .u_rbs24_seq_out (dout),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_random) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: latency at first out_valid, value at handshake, and the cycle after
    // a handshake must show out_valid low with the result held.
    initial begin : p_monitor
        bit         seen;
        bit         chk_low;
        logic [N:0] last_out;
        item_t      it;
        seen     = 0;
        chk_low  = 0;
        last_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen    = 0;
                chk_low = 0;
            end else begin
                if (chk_low) begin
                    check("post_hs_out_valid", {24'd0, out_valid}, 25'd0);
                    check("post_hs_hold", dout, last_out);
                    chk_low = 0;
                end
                if (out_valid && !seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: actual=1 required=0 (no pending op)");
                    end else begin
                        check("latency", (N + 1)'(cyc - sb[0].acc), (N + 1)'(LAT));
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() != 0) begin
                        it = sb.pop_front();
                        check("result", dout, it.exp);
                    end
                    seen     = 0;
                    chk_low  = 1;
                    last_out = dout;
                end
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic [N:0] exp,
                        input int stall);
        bit    done;
        item_t it;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
        end
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        done     = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                it.exp = exp;
                it.acc = cyc + 1;
                sb.push_back(it);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: they must be ignored after acceptance.
        a = N'($urandom);
        b = N'($urandom);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 5000 && !done; t++) begin
            if (sb.size() == 0) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit done;
        done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (out_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: out_valid actual=0 required=1");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : p_main
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #1;
        check("reset_in_ready", {24'd0, in_ready}, 25'd1);
        check("reset_out_valid", {24'd0, out_valid}, 25'd0);
        check("reset_busy", {24'd0, busy}, 25'd0);
        check("reset_out", dout, 25'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic vectors.
        send(24'h000005, 24'h000003, 25'h0000002, 0);
        drain();
        send(24'h000003, 24'h000005, 25'h1FFFFFE, 0);
        send(24'h000000, 24'hFFFFFF, 25'h1000001, 0);
        send(24'hFFFFFF, 24'h000001, 25'h0FFFFFE, 0);
        send(24'hABCDEF, 24'hABCDEF, 25'h0000000, 0);
        send(24'h5A5A5A, 24'h000000, 25'h05A5A5A, 1);
        send(24'h000000, 24'h000001, 25'h1FFFFFF, 2);
        drain();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        send(24'h123456, 24'h012345, 25'h0111111, 0);
        wait_out_valid();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_out_valid", {24'd0, out_valid}, 25'd1);
            check("bp_out", dout, 25'h0111111);
            check("bp_in_ready", {24'd0, in_ready}, 25'd0);
        end
        @(posedge clk);
        #1;
        // in_valid asserted in the output handshake cycle must not be accepted.
        out_ready = 1'b1;
        a         = 24'h000100;
        b         = 24'h000001;
        in_valid  = 1'b1;
        @(negedge clk);
        check("hs_cycle_in_ready", {24'd0, in_ready}, 25'd0);
        @(posedge clk);
        #1;
        check("after_hs_in_ready", {24'd0, in_ready}, 25'd1);
        check("after_hs_busy", {24'd0, busy}, 25'd0);
        send(24'h000100, 24'h000001, 25'h00000FF, 0);
        drain();

        // Asynchronous reset during the third RUN cycle discards the operation.
        send(24'h777777, 24'h111111, 25'h0666666, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {24'd0, out_valid}, 25'd0);
        check("abort_busy", {24'd0, busy}, 25'd0);
        check("abort_in_ready", {24'd0, in_ready}, 25'd1);
        check("abort_out", dout, 25'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_valid", {24'd0, out_valid}, 25'd0);
        end
        @(posedge clk);
        #1;
        send(24'h000010, 24'h000001, 25'h000000F, 0);
        drain();

        // Random sweep with input gaps and output stalls.
        rdy_random = 1;
        for (int k = 0; k < 300; k++) begin
            ra = N'($urandom);
            rb = (k % 16 == 0) ? ra : N'($urandom);
            send(ra, rb, ({1'b0, ra} - {1'b0, rb}), int'($urandom_range(0, 2)));
        end
        drain();
        rdy_random = 0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/u_rbs24_seq.md
Name: u_rbs24_seq

Overview:
- Sequential, digit-serial unsigned ripple-borrow subtractor. It is the inverse-direction companion to the library's 24-bit unsigned ripple-carry adder.
- Computes a - b over N bits, CHUNK bits per cycle, with a single borrow bit carried between cycles.
- Returns an (N+1)-bit result: difference mod 2^N in the low bits, borrow-out in the MSB.
- Sits behind valid/ready handshakes so it can be used as a low-area arithmetic unit in streaming datapaths.

Parameters:
- N, 24, operand width in bits.
- CHUNK, 4, bits processed per cycle. Must divide N; elaboration fails otherwise.

Ports:
- clk  input  1  clock; rising edge active.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned.
- b  input  N  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- u_rbs24_seq_out  output  N+1  [N-1:0] = (a-b) mod 2^N; [N] = borrow (1 iff a < b).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, u_rbs24_seq_out=0.
  - Internal operand, result, borrow and chunk-count registers are cleared.
  - Reset asserted mid-RUN or in DONE aborts the operation and discards it; no result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch a and b, clear borrow, set count=0, go to RUN.
  - in_valid=0 holds IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge takes the low CHUNK bits of the a and b shift registers plus borrow.
  - It computes the CHUNK-bit difference and the new borrow, as a chained per-bit full subtractor:
    - d = x ^ y ^ bin
    - bout = (~x & y) | (~(x ^ y) & bin)
  - It inserts the chunk into the result register from the top (shift right by CHUNK) and shifts both operand registers right by CHUNK.
  - count then increments.
  - After the edge where count reaches N/CHUNK-1, the state goes to DONE.
  - in_valid is ignored in RUN.
- Latency: with the operand handshake at edge E0, chunks are computed on edges E0+1 .. E0+N/CHUNK. out_valid is high from edge E0+N/CHUNK, which is 6 cycles for the defaults.
- DONE:
  - out_valid=1.
  - u_rbs24_seq_out = {borrow, result}, held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid drops, u_rbs24_seq_out holds its last value, and the state returns to IDLE.
  - The next operand pair can be accepted at the earliest one edge after the output handshake. There is no overlap of input and output handshakes.
- Arithmetic rules:
  - Result bit i equals bit i of a + ~b + 1, truncated to N bits.
  - Bit N equals NOT(carry-out) of that sum, i.e. the borrow.
  - Wrap-around is modular; there is no saturation.
- Boundary cases:
  - a == b gives {0, 0}.
  - b = 0 gives {0, a}.
  - a = 0, b ≠ 0 gives {1, 2^N - b}.
  - in_valid is asserted in the same cycle as the output handshake: it is not accepted, because in_ready=0 in DONE. It is accepted on the following edge if it is still held.
  - out_ready held high permanently: the result is visible for exactly one cycle.
- Operand inputs are sampled only at acceptance. Changes to a and b during RUN or DONE have no effect.

Test Plan:
- Reset, then a=0x000005, b=0x000003 -> out_valid rises 6 cycles after acceptance, u_rbs24_seq_out=0x0000002.
- a=0x000003, b=0x000005 -> u_rbs24_seq_out=0x1FFFFFE, borrow=1.
- a=0x000000, b=0xFFFFFF -> 0x1000001. Then a=0xFFFFFF, b=0x000001 -> 0x0FFFFFE. Then a=b=0xABCDEF -> 0x0000000.
- Backpressure, with a=0x123456, b=0x012345 -> result 0x0111111:
  - Hold out_ready=0 for 10 cycles -> out_valid and the result stay stable and in_ready=0.
  - Then raise out_ready for one cycle -> the FSM returns to IDLE.
- Assert rst asynchronously (mid-clock) at the 3rd RUN cycle -> outputs go to zero immediately, no out_valid appears, and the next operation (a=0x000010, b=0x000001) yields 0x000000F.
- Random sweep of 10k pairs with random in_valid/out_ready stalls -> every result matches {a<b, (a-b) mod 2^24}. Also repeat with CHUNK=1, 8 and 24 (latencies 24, 3 and 1).
